// File: rtl/icache_assoc_param_if.sv
// ---------------------------------------------------------------------------
// icache_assoc_param_if
//
// Bundles the two buses of the instruction cache:
//   - the fetch side (s_*): address request from the IF stage and the
//     one-cycle instruction response back to it;
//   - the AXI read side (m_*): AR channel and R channel toward memory.
//
// Modports:
//   slave  : the cache itself. It serves fetch requests and drives the
//            AXI read master outputs.
//   master : everything around the cache (IF stage plus the AXI read
//            slave / interconnect).
//
// Signals:
//   s_araddr  [ADDR_W]  fetch address, word aligned
//   s_arvalid           fetch request
//   s_arready           cache can accept a request this cycle
//   s_rdata   [32]      fetched instruction
//   s_rvalid            one-cycle response pulse
//   m_araddr  [ADDR_W]  AXI AR address
//   m_arlen   [8]       AXI AR length (beats-1)
//   m_arvalid           AXI AR valid
//   m_arready           AXI AR ready
//   m_rdata   [32]      AXI R data
//   m_rvalid            AXI R valid
//   m_rlast             AXI R last
//   m_rready            AXI R ready (always 1)
// ---------------------------------------------------------------------------
interface icache_assoc_param_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic              s_rvalid;

  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic              m_arvalid;
  logic              m_arready;
  logic [31:0]       m_rdata;
  logic              m_rvalid;
  logic              m_rlast;
  logic              m_rready;

  modport slave (
    input  s_araddr, s_arvalid,
    output s_arready, s_rdata, s_rvalid,
    output m_araddr, m_arlen, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rvalid, m_rlast
  );

  modport master (
    output s_araddr, s_arvalid,
    input  s_arready, s_rdata, s_rvalid,
    input  m_araddr, m_arlen, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rvalid, m_rlast
  );

endinterface

// File: rtl/icache_assoc_param.sv
// ---------------------------------------------------------------------------
// icache_assoc_param
//
// N-way set-associative instruction cache sitting between the IF stage and
// an AXI read master. One request is handled at a time.
//
//   - Cached fetch: tag lookup in all ways of the indexed set. A hit answers
//     two cycles after accept. A miss issues an INCR burst for the whole line,
//     writes the beats straight into the chosen victim way and answers with
//     the requested word once the last beat arrives.
//   - Uncached fetch (cache_ena=0 at accept): single-beat AR at the exact
//     address; the arrays are left untouched.
//   - Replacement: lowest-index invalid way, otherwise the per-set
//     round-robin pointer (which then advances).
//   - flush: blocks accept in IDLE; anywhere else it only suppresses the
//     response of the request in flight. AXI traffic always completes.
//   - invalidate: remembered until the next IDLE cycle, where every valid
//     bit is cleared (accept is held off during that cycle).
//
// Parameters:
//   WAYS        ways per set (power of 2, >= 2)
//   SETS        number of sets (power of 2, >= 2)
//   LINE_WORDS  32-bit words per line (power of 2, 2..256)
//   ADDR_W      address width
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   cache_ena   1 = cached fetch, 0 = uncached (sampled with the request)
//   invalidate  pulse: clear all valid bits at the next IDLE cycle
//   flush       pipeline flush
//   bus         fetch + AXI read bus (slave modport)
// ---------------------------------------------------------------------------
module icache_assoc_param #(
  parameter int WAYS       = 4,
  parameter int SETS       = 4,
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_ena,
  input  logic                  invalidate,
  input  logic                  flush,
  icache_assoc_param_if.slave   bus
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(WAYS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_AR,
    ST_REFILL,
    ST_UNC_AR,
    ST_UNC_R,
    ST_RESP
  } state_t;

  state_t              state_reg;

  // Word address of the request being served (byte offset dropped).
  logic [ADDR_W-3:0]   waddr_reg;
  logic [WAYS-1:0]     valid_reg  [SETS];
  logic [WAY_W-1:0]    rr_ptr_reg [SETS];
  logic [WAY_W-1:0]    victim_reg;
  logic [WORD_W-1:0]   beat_cnt_reg;
  logic                drop_reg;
  logic                inv_pend_reg;

  logic                s_rvalid_reg;
  logic [31:0]         s_rdata_reg;
  logic                m_arvalid_reg;
  logic [ADDR_W-1:0]   m_araddr_reg;
  logic [7:0]          m_arlen_reg;

  // Fields of the latched request.
  logic [TAG_W-1:0]    tag_f;
  logic [IDX_W-1:0]    idx_f;
  logic [WORD_W-1:0]   word_f;

  // Fields of the incoming request, used to start the array read at accept.
  logic [IDX_W-1:0]    s_idx;
  logic [WORD_W-1:0]   s_word;

  logic                accept;
  logic                data_we;
  logic                tag_we;

  logic [WAYS-1:0]        hit_vec;
  logic [WAYS-1:0][31:0]  way_data;
  logic                   hit;
  logic [31:0]            hit_word;
  logic [WAY_W-1:0]       victim_next;
  logic                   all_valid;

  assign tag_f  = waddr_reg[ADDR_W-3 -: TAG_W];
  assign idx_f  = waddr_reg[WORD_W +: IDX_W];
  assign word_f = waddr_reg[0 +: WORD_W];

  assign s_idx  = bus.s_araddr[OFF_W +: IDX_W];
  assign s_word = bus.s_araddr[2 +: WORD_W];

  assign bus.s_arready = (state_reg == ST_IDLE) && !inv_pend_reg && !flush;
  assign accept        = bus.s_arready && bus.s_arvalid;

  // Refill beats go directly into the victim way; the tag is written with the
  // last beat, at the same time the valid bit is set.
  assign data_we = (state_reg == ST_REFILL) && bus.m_rvalid;
  assign tag_we  = data_we && bus.m_rlast;

  assign bus.s_rvalid  = s_rvalid_reg;
  assign bus.s_rdata   = s_rdata_reg;
  assign bus.m_arvalid = m_arvalid_reg;
  assign bus.m_araddr  = m_araddr_reg;
  assign bus.m_arlen   = m_arlen_reg;
  assign bus.m_rready  = 1'b1;

  // -------------------------------------------------------------------------
  // Per-way tag and data arrays. Reads are registered and launched at accept,
  // so the LOOKUP cycle sees the tag and the addressed word of every way.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0] tag_mem  [SETS];
      logic [31:0]      data_mem [SETS*LINE_WORDS];
      logic [TAG_W-1:0] tag_rd_reg;
      logic [31:0]      data_rd_reg;
      logic             way_sel;

      assign way_sel = (victim_reg == WAY_W'(gi));

      always_ff @(posedge clk) begin
        if (tag_we && way_sel) begin
          tag_mem[idx_f] <= tag_f;
        end
        if (data_we && way_sel) begin
          data_mem[{idx_f, beat_cnt_reg}] <= bus.m_rdata;
        end
        if (accept) begin
          tag_rd_reg  <= tag_mem[s_idx];
          data_rd_reg <= data_mem[{s_idx, s_word}];
        end
      end

      assign hit_vec[gi]  = valid_reg[idx_f][gi] && (tag_rd_reg == tag_f);
      assign way_data[gi] = data_rd_reg;
    end
  endgenerate

  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) begin
        hit      = 1'b1;
        hit_word = way_data[w];
      end
    end
  end

  // Descending scan so the lowest-index invalid way wins; with no invalid
  // way the set's round-robin pointer is the victim.
  always_comb begin
    victim_next = rr_ptr_reg[idx_f];
    all_valid   = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_reg[idx_f][w]) begin
        victim_next = WAY_W'(w);
        all_valid   = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      waddr_reg     <= '0;
      victim_reg    <= '0;
      beat_cnt_reg  <= '0;
      drop_reg      <= 1'b0;
      inv_pend_reg  <= 1'b0;
      s_rvalid_reg  <= 1'b0;
      s_rdata_reg   <= '0;
      m_arvalid_reg <= 1'b0;
      m_araddr_reg  <= '0;
      m_arlen_reg   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s]  <= '0;
        rr_ptr_reg[s] <= '0;
      end
    end else begin
      s_rvalid_reg <= 1'b0;

      if (invalidate) begin
        inv_pend_reg <= 1'b1;
      end

      // A flush while a request is in flight only marks its response as
      // dropped; the state sequence itself is unaffected.
      if (state_reg != ST_IDLE && flush) begin
        drop_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (inv_pend_reg) begin
            for (int s = 0; s < SETS; s++) begin
              valid_reg[s] <= '0;
            end
            // A new pulse in this very cycle keeps the request pending.
            inv_pend_reg <= invalidate;
          end else if (accept) begin
            waddr_reg <= bus.s_araddr[ADDR_W-1:2];
            if (cache_ena) begin
              state_reg <= ST_LOOKUP;
            end else begin
              m_arvalid_reg <= 1'b1;
              m_araddr_reg  <= bus.s_araddr;
              m_arlen_reg   <= 8'd0;
              state_reg     <= ST_UNC_AR;
            end
          end
        end

        ST_LOOKUP: begin
          if (hit) begin
            s_rdata_reg  <= hit_word;
            s_rvalid_reg <= !(drop_reg || flush);
            state_reg    <= ST_RESP;
          end else begin
            // The victim is fixed now; nothing can change the set's valid
            // bits or pointer before the refill finishes.
            victim_reg <= victim_next;
            if (all_valid) begin
              rr_ptr_reg[idx_f] <= rr_ptr_reg[idx_f] + 1'b1;
            end
            beat_cnt_reg  <= '0;
            m_arvalid_reg <= 1'b1;
            m_araddr_reg  <= {waddr_reg[ADDR_W-3:WORD_W], {OFF_W{1'b0}}};
            m_arlen_reg   <= 8'(LINE_WORDS - 1);
            state_reg     <= ST_AR;
          end
        end

        ST_AR: begin
          if (bus.m_arready) begin
            m_arvalid_reg <= 1'b0;
            state_reg     <= ST_REFILL;
          end
        end

        ST_REFILL: begin
          if (bus.m_rvalid) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (beat_cnt_reg == word_f) begin
              s_rdata_reg <= bus.m_rdata;
            end
            if (bus.m_rlast) begin
              valid_reg[idx_f][victim_reg] <= 1'b1;
              s_rvalid_reg                 <= !(drop_reg || flush);
              state_reg                    <= ST_RESP;
            end
          end
        end

        ST_UNC_AR: begin
          if (bus.m_arready) begin
            m_arvalid_reg <= 1'b0;
            state_reg     <= ST_UNC_R;
          end
        end

        ST_UNC_R: begin
          if (bus.m_rvalid) begin
            s_rdata_reg  <= bus.m_rdata;
            s_rvalid_reg <= !(drop_reg || flush);
            state_reg    <= ST_RESP;
          end
        end

        ST_RESP: begin
          drop_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_assoc_param.sv
// ---------------------------------------------------------------------------
// tb_icache_assoc_param
//
// Drives fetches into icache_assoc_param while playing the AXI read slave.
// Memory content is a fixed function of the word address. A small model of
// set contents (valid/tag per way, round-robin pointer per set) predicts
// hit or miss for each fetch; from that follow the expected AR traffic,
// response count, latency and data.
// ---------------------------------------------------------------------------
module tb_icache_assoc_param;

  localparam int WAYS       = 4;
  localparam int SETS       = 4;
  localparam int LINE_WORDS = 16;
  localparam int ADDR_W     = 32;

  logic clk;
  logic rst;
  logic cache_ena;
  logic invalidate;
  logic flush;

  icache_assoc_param_if #(.ADDR_W(ADDR_W)) bus ();

  icache_assoc_param #(
    .WAYS       (WAYS),
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cache_ena  (cache_ena),
    .invalidate (invalidate),
    .flush      (flush),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int txn_no;
  bit use_dead;

  // Model of cache contents.
  bit          mval [SETS][WAYS];
  logic [23:0] mtag [SETS][WAYS];
  int          mrr  [SETS];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (use_dead) return 32'h0000_DEAD;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] mk_addr(input logic [23:0] t, input int s, input int w);
    logic [31:0] a;
    a = {t, s[1:0], w[3:0], 2'b00};
    return a;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) mval[s][w] = 1'b0;
  endfunction

  function automatic bit model_hit(input logic [23:0] t, input int s);
    for (int w = 0; w < WAYS; w++)
      if (mval[s][w] && mtag[s][w] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_install(input logic [23:0] t, input int s);
    int v;
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (!mval[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = mrr[s];
      mrr[s] = (mrr[s] + 1) % WAYS;
    end
    mval[s][v] = 1'b1;
    mtag[s][v] = t;
  endfunction

  task automatic drive_idle();
    bus.s_araddr  = '0;
    bus.s_arvalid = 1'b0;
    bus.m_arready = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rvalid  = 1'b0;
    bus.m_rlast   = 1'b0;
    cache_ena     = 1'b1;
    invalidate    = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int s = 0; s < SETS; s++) mrr[s] = 0;
  endtask

  // One fetch: request, AXI slave behaviour, and all per-fetch comparisons.
  task automatic do_fetch(input logic [31:0] addr, input bit ena, input int flush_beat,
                          input int ar_delay, input int inv_cycle);
    logic [23:0] tag;
    int          idx, exp_len, ar_count, arv_cycles, resp_count, resp_k, beats_sent, wait_left, k;
    bit          exp_hit, exp_drop, ar_seen, ar_done, done;
    logic [31:0] exp_base, exp_data, resp_data;

    tag        = addr[31:8];
    idx        = int'(addr[7:6]);
    exp_hit    = ena && model_hit(tag, idx);
    exp_base   = ena ? {addr[31:6], 6'b0} : addr;
    exp_len    = ena ? LINE_WORDS - 1 : 0;
    exp_drop   = !exp_hit && (flush_beat >= 0);
    exp_data   = mem_word(addr);
    ar_count   = 0;
    arv_cycles = 0;
    resp_count = 0;
    resp_k     = -1;
    beats_sent = 0;
    wait_left  = 0;
    ar_seen    = 1'b0;
    ar_done    = 1'b0;
    done       = 1'b0;
    resp_data  = '0;

    @(negedge clk);
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    cache_ena     = ena;
    #1;
    k = 0;
    while (!bus.s_arready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!bus.s_arready) begin
      check_val("accept_timeout", 32'd0, 32'd1);
      bus.s_arvalid = 1'b0;
      do_reset();
      return;
    end
    @(posedge clk);
    #1;
    bus.s_arvalid = 1'b0;

    for (k = 1; k <= 400 && !done; k++) begin
      @(negedge clk);
      if (bus.s_rvalid) begin
        resp_count++;
        resp_data = bus.s_rdata;
        if (resp_k < 0) resp_k = k;
      end
      if (bus.m_arvalid) begin
        arv_cycles++;
        check_val("ar_addr", bus.m_araddr, exp_base);
        check_val("ar_len", 32'(bus.m_arlen), 32'(exp_len));
      end
      if (bus.s_arready) done = 1'b1;

      bus.m_arready = 1'b0;
      bus.m_rvalid  = 1'b0;
      bus.m_rlast   = 1'b0;
      bus.m_rdata   = $urandom;
      flush         = 1'b0;
      invalidate    = 1'b0;
      if (!done) begin
        if (k == inv_cycle) invalidate = 1'b1;
        if (ar_done && beats_sent <= exp_len) begin
          if ($urandom_range(0, 3) != 0) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = mem_word(exp_base + 32'(4 * beats_sent));
            bus.m_rlast  = (beats_sent == exp_len);
            if (beats_sent == flush_beat) flush = 1'b1;
            beats_sent++;
          end
        end else if (!ar_done && $urandom_range(0, 7) == 0) begin
          // Stray R beat while no read burst is open: must be ignored.
          bus.m_rvalid = 1'b1;
          bus.m_rlast  = 1'b1;
        end
        if (bus.m_arvalid && !ar_done) begin
          if (!ar_seen) begin
            ar_seen   = 1'b1;
            wait_left = ar_delay;
          end
          if (wait_left == 0) begin
            bus.m_arready = 1'b1;
            ar_done       = 1'b1;
            ar_count++;
          end else begin
            wait_left--;
          end
        end
      end
    end

    if (!done) begin
      check_val("txn_timeout", 32'd0, 32'd1);
      do_reset();
      return;
    end

    check_val("ar_count", 32'(ar_count), exp_hit ? 32'd0 : 32'd1);
    check_val("arvalid_cycles", 32'(arv_cycles), exp_hit ? 32'd0 : 32'(ar_delay + 1));
    check_val("resp_count", 32'(resp_count), exp_drop ? 32'd0 : 32'd1);
    if (!exp_drop) check_val("rdata", resp_data, exp_data);
    if (exp_hit) check_val("hit_latency", 32'(resp_k), 32'd2);

    if (ena && !exp_hit) model_install(tag, idx);
    if (inv_cycle > 0) model_clear();

    $display("txn %0d addr=%h ena=%0d hit=%0d ar=%0d resp=%0d data=%h flush_beat=%0d inv=%0d",
             txn_no, addr, ena, exp_hit, ar_count, resp_count, resp_data, flush_beat, inv_cycle);
    txn_no++;
  endtask

  initial begin
    logic [31:0] a;
    int          ena_i, len, fb, inv;
    checks   = 0;
    errors   = 0;
    txn_no   = 0;
    use_dead = 1'b0;
    rst      = 1'b1;
    drive_idle();
    do_reset();

    // Reset state.
    #1;
    check_val("rst_s_rvalid", 32'(bus.s_rvalid), 32'd0);
    check_val("rst_s_rdata", bus.s_rdata, 32'd0);
    check_val("rst_m_arvalid", 32'(bus.m_arvalid), 32'd0);
    check_val("rst_m_araddr", bus.m_araddr, 32'd0);
    check_val("rst_m_arlen", 32'(bus.m_arlen), 32'd0);
    check_val("rst_s_arready", 32'(bus.s_arready), 32'd1);
    check_val("rst_m_rready", 32'(bus.m_rready), 32'd1);

    // Cold miss, then hit in the same line.
    do_fetch(32'hBFC0_0004, 1'b1, -1, 1, 0);
    do_fetch(32'hBFC0_0008, 1'b1, -1, 0, 0);

    // flush together with a request in IDLE: nothing is accepted.
    @(negedge clk);
    bus.s_araddr  = 32'hBFC0_0008;
    bus.s_arvalid = 1'b1;
    cache_ena     = 1'b1;
    flush         = 1'b1;
    #1;
    check_val("flush_blocks_arready", 32'(bus.s_arready), 32'd0);
    @(negedge clk);
    check_val("flush_no_resp", 32'(bus.s_rvalid), 32'd0);
    bus.s_arvalid = 1'b0;
    flush         = 1'b0;
    #1;
    check_val("idle_after_flush", 32'(bus.s_arready), 32'd1);

    // Five tags into set 1: fills ways 0..3, the fifth evicts way 0.
    for (int i = 0; i < 5; i++)
      do_fetch(mk_addr(24'h100001 + 24'(i), 1, i), 1'b1, -1, 0, 0);
    do_fetch(mk_addr(24'h100002, 1, 3), 1'b1, -1, 0, 0);
    do_fetch(mk_addr(24'h100001, 1, 7), 1'b1, -1, 0, 0);

    // Uncached fetch, then the same address cached still misses.
    use_dead = 1'b1;
    do_fetch(32'h1FC0_0010, 1'b0, -1, 1, 0);
    use_dead = 1'b0;
    do_fetch(32'h1FC0_0010, 1'b1, -1, 0, 0);

    // Flush on refill beat 5: no response, line still installed.
    do_fetch(32'h8000_0080, 1'b1, 5, 0, 0);
    do_fetch(32'h8000_0084, 1'b1, -1, 0, 0);

    // Invalidate, then a previously filled address misses again.
    @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    #1;
    check_val("inv_blocks_arready", 32'(bus.s_arready), 32'd0);
    @(negedge clk);
    #1;
    check_val("arready_after_inv", 32'(bus.s_arready), 32'd1);
    model_clear();
    do_fetch(32'hBFC0_0008, 1'b1, -1, 3, 0);

    // Randomized traffic over a small tag pool to force hits and evictions.
    for (int n = 0; n < 200; n++) begin
      a     = mk_addr(24'hC00000 + 24'($urandom_range(0, 5)),
                      int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, LINE_WORDS - 1)));
      ena_i = ($urandom_range(0, 9) != 0) ? 1 : 0;
      len   = (ena_i != 0) ? LINE_WORDS - 1 : 0;
      fb    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
      inv   = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_fetch(a, ena_i != 0, fb, int'($urandom_range(0, 3)), inv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
